// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC waveform capture path: default sizes,
// the capture state encoding and the circular-address wrap helper.
package adc_capture_pkg;

  localparam int CAP_DATA_W   = 14;
  localparam int CAP_DEPTH    = 1000;
  localparam int CAP_PRE_TRIG = 100;
  localparam int CAP_ADDR_W   = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    READY   = 3'd4
  } cap_state_e;

  // Folds a pointer sum/difference that is at most one DEPTH outside
  // [0, depth) back into range with a single +depth / -depth correction.
  function automatic int wrap_addr(input int v, input int depth);
    int r;
    r = v;
    if (r < 0) begin
      r = r + depth;
    end else if (r >= depth) begin
      r = r - depth;
    end
    return r;
  endfunction

endpackage

// File: rtl/wave_capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Written so that the array maps onto block RAM.
module wave_capture_ram #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: one sample per enabled cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: registered output, one cycle latency.
  always_ff @(posedge clk) begin
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/wave_capture_buffer.sv
// Pretrigger/posttrigger capture of one ADC channel into a circular RAM.
// The window is frozen once DEPTH samples around the trigger are stored and
// is read back through an addressed, one-cycle-latency port.
// Optional: define WAVE_CAPTURE_TIMESTAMP_EN to latch a 32-bit cycle count at
// the accepted trigger, readable at read_addr DEPTH (low) and DEPTH+1 (high).
module wave_capture_buffer
  import adc_capture_pkg::*;
#(
  parameter int DATA_W   = CAP_DATA_W,
  parameter int DEPTH    = CAP_DEPTH,
  parameter int PRE_TRIG = CAP_PRE_TRIG,
  parameter int ADDR_W   = CAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              trigger_in,
  input  logic              arm,
  input  logic [15:0]       read_addr,
  output logic [15:0]       read_data,
  input  logic              read_done,
  output logic              wave_ready,
  output logic [15:0]       wave_number
);

  localparam logic [ADDR_W-1:0] POST_LEN = ADDR_W'(DEPTH - PRE_TRIG - 1);

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
  logic              ready_q, ready_d;
  logic [15:0]       num_q, num_d;
  logic              trig_d_q;
  logic              trig_edge;
  logic              trig_accept;
  logic              we;

  logic              in_range;
  logic [ADDR_W-1:0] base_w, phys_w, raddr_w;
  logic [DATA_W-1:0] ram_rdata;
  logic              use_ram_q, use_ram_d;
  logic [15:0]       const_q, const_d;

  assign trig_edge = trigger_in & ~trig_d_q;

  // Next-state logic for the capture sequence.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    post_d      = post_q;
    trig_ptr_d  = trig_ptr_q;
    ready_d     = ready_q;
    num_d       = num_q;
    we          = 1'b0;
    trig_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = PREFILL;
          fill_d  = '0;
        end
      end
      PREFILL: begin
        if (!arm) begin
          state_d = IDLE;
          fill_d  = '0;
        end else begin
          we     = 1'b1;
          fill_d = fill_q + 1'b1;
          if (fill_d == ADDR_W'(PRE_TRIG)) begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        // A trigger edge beats a simultaneous disarm.
        if (trig_edge) begin
          we          = 1'b1;
          trig_accept = 1'b1;
          trig_ptr_d  = wr_ptr_q;
          post_d      = POST_LEN;
          if (POST_LEN == '0) begin
            state_d = READY;
            ready_d = 1'b1;
            num_d   = num_q + 16'd1;
          end else begin
            state_d = POST;
          end
        end else if (!arm) begin
          state_d = IDLE;
          fill_d  = '0;
        end else begin
          we = 1'b1;
        end
      end
      POST: begin
        we     = 1'b1;
        post_d = post_q - 1'b1;
        if (post_q == ADDR_W'(1)) begin
          state_d = READY;
          ready_d = 1'b1;
          num_d   = num_q + 16'd1;
        end
      end
      READY: begin
        if (read_done) begin
          ready_d = 1'b0;
          fill_d  = '0;
          state_d = arm ? PREFILL : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_ptr_d = !we ? wr_ptr_q :
                    (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      trig_ptr_q <= '0;
      ready_q    <= 1'b0;
      num_q      <= '0;
      trig_d_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      trig_ptr_q <= trig_ptr_d;
      ready_q    <= ready_d;
      num_q      <= num_d;
      trig_d_q   <= trigger_in;
    end
  end

  // Post-trigger down-counter; always loaded before it is used.
  always_ff @(posedge clk) begin
    post_q <= post_d;
  end

  // Map the waveform index onto the circular buffer: oldest pretrigger
  // sample sits PRE_TRIG entries behind the trigger sample.
  always_comb begin
    in_range = (read_addr < 16'(DEPTH));
    base_w   = ADDR_W'(wrap_addr(int'(trig_ptr_q) - PRE_TRIG, DEPTH));
    phys_w   = ADDR_W'(wrap_addr(int'(base_w) + int'(read_addr[ADDR_W-1:0]), DEPTH));
    raddr_w  = in_range ? phys_w : '0;
  end

  wave_capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (sample_in),
    .raddr_i (raddr_w),
    .rdata_o (ram_rdata)
  );

`ifdef WAVE_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] ts_q;

  // Free-running cycle counter and its snapshot at the accepted trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (trig_accept) begin
        ts_q <= ts_cnt_q;
      end
    end
  end
`endif

  // Select the readback source for the out-of-range and timestamp addresses.
  always_comb begin
    use_ram_d = in_range;
    const_d   = '0;
`ifdef WAVE_CAPTURE_TIMESTAMP_EN
    if (read_addr == 16'(DEPTH)) begin
      const_d = ts_q[15:0];
    end else if (read_addr == 16'(DEPTH + 1)) begin
      const_d = ts_q[31:16];
    end
`endif
  end

  // Read-source registers aligned with the RAM output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      use_ram_q <= 1'b0;
      const_q   <= '0;
    end else begin
      use_ram_q <= use_ram_d;
      const_q   <= const_d;
    end
  end

  assign read_data   = use_ram_q ? 16'(ram_rdata) : const_q;
  assign wave_ready  = ready_q;
  assign wave_number = num_q;

endmodule
